// File: rtl/duty_bcd_converter.sv
// Purpose : binary-to-packed-BCD converter (sequential double-dabble, one bit per clock)
//           between the duty/frequency measurement stage and the OLED display driver.
// Latency : in_valid at edge N -> out_valid high in the cycle after edge N+DATAWIDTH+1.
// Backpressure: none upstream; one pending slot, newest sample wins, overrun pulses on overwrite.
//
// Ports:
//   sys_clk, sys_rst_n  clock (rising edge) and asynchronous active-low reset
//   bin_in, in_valid    binary sample and its one-cycle strobe
//   bcd_out             packed BCD, digit 0 (units) in [3:0], held between updates
//   digit_cnt           significant digit count, 1..DIGITS (zero reports 1)
//   out_valid           one-cycle pulse coinciding with the bcd_out/digit_cnt update
//   busy                high while converting (SHIFT or DONE)
//   overrun             one-cycle pulse when an unconsumed pending sample is replaced
module duty_bcd_converter #(
   parameter int DATAWIDTH = 30,
   parameter int DIGITS    = 10,
   parameter int CNTW      = 4
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst_n,
   input  logic [DATAWIDTH-1:0]  bin_in,
   input  logic                  in_valid,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [CNTW-1:0]       digit_cnt,
   output logic                  out_valid,
   output logic                  busy,
   output logic                  overrun
);

   localparam int BW  = 4 * DIGITS;
   localparam int ITW = $clog2(DATAWIDTH + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t                state;
   logic [DATAWIDTH-1:0]  shreg;
   logic [BW-1:0]         scratch;
   logic [ITW-1:0]        bit_cnt;
   logic [DATAWIDTH-1:0]  pend_dat;
   logic                  pend_flg;

   logic [BW-1:0]         adj;
   logic [CNTW-1:0]       sig_cnt;

   // Double-dabble correction: any digit >= 5 would carry past 9 after the
   // doubling shift, so pre-add 3 to push it into the next digit instead.
   always_comb begin
      adj = scratch;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // Highest nonzero digit index + 1; an all-zero value still shows one digit.
   always_comb begin
      sig_cnt = CNTW'(1);
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch[4*i +: 4] != 4'd0)
            sig_cnt = CNTW'(i + 1);
      end
   end

   assign busy = (state != IDLE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state     <= IDLE;
         shreg     <= '0;
         scratch   <= '0;
         bit_cnt   <= '0;
         pend_dat  <= '0;
         pend_flg  <= 1'b0;
         bcd_out   <= '0;
         digit_cnt <= CNTW'(1);
         out_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         overrun   <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid) begin
                  shreg   <= bin_in;
                  scratch <= '0;
                  bit_cnt <= '0;
                  state   <= SHIFT;
               end
            end
            SHIFT: begin
               scratch <= {adj[BW-2:0], shreg[DATAWIDTH-1]};
               shreg   <= {shreg[DATAWIDTH-2:0], 1'b0};
               bit_cnt <= bit_cnt + 1'b1;
               if (bit_cnt == ITW'(DATAWIDTH - 1))
                  state <= DONE;
               // New samples never touch the running conversion; they park in
               // the single pending slot, replacing anything already there.
               if (in_valid) begin
                  pend_dat <= bin_in;
                  pend_flg <= 1'b1;
                  overrun  <= pend_flg;
               end
            end
            DONE: begin
               bcd_out   <= scratch;
               digit_cnt <= sig_cnt;
               out_valid <= 1'b1;
               // A fresh strobe this cycle outranks the parked sample.
               if (in_valid) begin
                  shreg    <= bin_in;
                  scratch  <= '0;
                  bit_cnt  <= '0;
                  pend_flg <= 1'b0;
                  state    <= SHIFT;
               end else if (pend_flg) begin
                  shreg    <= pend_dat;
                  scratch  <= '0;
                  bit_cnt  <= '0;
                  pend_flg <= 1'b0;
                  state    <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/duty_bcd_converter.md
Name: duty_bcd_converter

Overview:
- Sits directly downstream of the duty-cycle/frequency measurement stage and consumes its 30-bit result plus its one-cycle valid pulse.
- Converts the binary result to packed BCD using sequential double-dabble, one bit per clock.
- Publishes held BCD digits, a significant-digit count and a one-cycle done pulse to the OLED display driver.
- Buffers one pending sample so a result arriving while a conversion is running is not lost; the newest pending sample wins.

Parameters:
- DATAWIDTH, 30, width of the binary input.
- DIGITS, 10, number of BCD digits produced. Must satisfy 10^DIGITS > 2^DATAWIDTH-1.
- CNTW, 4, width of digit_cnt. Must satisfy 2^CNTW > DIGITS.

Ports:
- sys_clk  in  1  system clock; all logic on its rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- bin_in  in  DATAWIDTH  binary value to convert; sampled only when in_valid=1.
- in_valid  in  1  one-cycle strobe qualifying bin_in.
- bcd_out  out  4*DIGITS  packed BCD, digit 0 (units) in bits [3:0]; held between updates.
- digit_cnt  out  CNTW  number of significant digits, 1..DIGITS; value 0 gives 1.
- out_valid  out  1  one-cycle pulse; bcd_out and digit_cnt are updated in the same cycle.
- busy  out  1  high while a conversion is in progress (states SHIFT and DONE).
- overrun  out  1  one-cycle pulse when an unconsumed pending sample is overwritten.

Behaviour:
- Reset values: bcd_out=0, digit_cnt=1, out_valid=0, busy=0, overrun=0; pending flag cleared; state=IDLE.
- Reset asserted mid-conversion aborts the conversion immediately: no out_valid, and any pending sample is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If in_valid=1: load bin_in into the shift register, clear the BCD scratch register, clear the bit counter, go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, one iteration per cycle:
  - Add 3 to every scratch BCD digit that is >=5.
  - Shift {scratch, shift_reg} left by 1.
  - Increment the bit counter.
  - After DATAWIDTH iterations, go to DONE.
- DONE, lasts one cycle:
  - Register scratch into bcd_out and compute digit_cnt (index of the highest nonzero digit + 1, minimum 1).
  - Pulse out_valid the following cycle.
  - Then, in priority order:
    - in_valid=1 this cycle: load bin_in, clear the pending flag, go to SHIFT.
    - Pending flag set: load the pending value, clear the flag, go to SHIFT.
    - Otherwise: go to IDLE.
- Latency: in_valid sampled at edge N gives out_valid high during the cycle after edge N+DATAWIDTH+1, i.e. 32 cycles for the default width.
- Throughput: one result per DATAWIDTH+1 cycles with back-to-back input.
- in_valid while in SHIFT:
  - Store bin_in in the pending register and set the pending flag.
  - If the flag was already set, overwrite it and pulse overrun for one cycle.
- The active conversion is never disturbed by new input.
- The digit_cnt computation is combinational from scratch, registered in DONE. No leading-zero blanking is performed here; the display uses digit_cnt.
- in_valid held high for several cycles is treated as one strobe per cycle: successive samples land in pending, and overrun fires on each overwrite.

Test Plan:
- Reset release, idle 5 cycles -> bcd_out=0, digit_cnt=1, out_valid, busy and overrun all 0.
- bin_in=50, single in_valid -> exactly one out_valid pulse 32 cycles later; bcd_out=0x0000000050, digit_cnt=2; busy high for 31 cycles.
- bin_in=0, then 1073741823 (2^30-1) -> bcd_out=0x0000000000 with digit_cnt=1, then bcd_out=0x1073741823 with digit_cnt=10.
- in_valid with 37, then during SHIFT 99, then 12 (before DONE) -> outputs 37 then 12, one overrun pulse, 99 never output.
- in_valid with 25, then in_valid with 64 exactly in the DONE cycle -> 25 output, then 64 output 31 cycles after that out_valid; no overrun.
- Start a conversion of 100, assert sys_rst_n low at iteration 15 for 2 cycles -> all outputs at reset values, no out_valid. New bin_in=7 after release -> bcd_out=0x7, digit_cnt=1 at the normal latency.
